// File: rtl/wb_uart_fifo.sv
// Wishbone-slave 8N1 UART with TX/RX FIFOs, run-time baud divisor
// and a maskable level interrupt.
module wb_uart_fifo_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [7:0]    din,
   input  logic          pop,
   output logic [7:0]    dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          do_push, do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   // a pop in the same cycle frees the slot for a push into a full FIFO
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | pop);
   assign dout    = mem[rp];

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module wb_uart_fifo #(
   parameter int          ADDRWIDTH          = 10,
   parameter int          FIFO_DEPTH         = 16,
   parameter logic [15:0] DEFAULT_DIV        = 16'd103,
   parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBADFABAC
) (
   input  logic                 WB_CLK,
   input  logic                 WB_RST,
   input  logic [ADDRWIDTH-1:0] WBs_ADR,
   input  logic                 WBs_CYC,
   input  logic                 WBs_STB,
   input  logic                 WBs_WE,
   input  logic [3:0]           WBs_BYTE_STB,
   input  logic [31:0]          WBs_WR_DAT,
   output logic [31:0]          WBs_RD_DAT,
   output logic                 WBs_ACK,
   input  logic                 UART_SIN_i,
   output logic                 UART_SOUT_o,
   output logic                 UART_Intr_o
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic          acc, wr, rd;
   logic [2:0]    sel;
   logic [15:0]   div, div_new;
   logic [2:0]    ie;
   logic          rx_ovr, frm_err, tx_ovf, err, tx_idle;
   logic          w1c;
   logic          tx_push, tx_pop, tx_full, tx_empty;
   logic          rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]    tx_head, rx_head;
   logic [CW-1:0] tx_count, rx_count;
   logic          tx_ovf_set, rx_ovr_set, frm_set;
   logic [31:0]   status, rdat;

   state_t        tx_st, rx_st;
   logic [15:0]   tx_cnt, tx_div, rx_cnt, rx_div;
   logic [7:0]    tx_sh, rx_sh;
   logic [2:0]    tx_bit, rx_bit;
   logic          s1, s2, s3;
   logic [16:0]   half;
   logic          unused;

   assign acc = WBs_CYC & WBs_STB & WBs_ACK;
   assign wr  = acc & WBs_WE;
   assign rd  = acc & ~WBs_WE;
   assign sel = WBs_ADR[4:2];
   assign w1c = wr & (sel == 3'd1) & WBs_BYTE_STB[0];

   assign tx_push    = wr & (sel == 3'd0) & WBs_BYTE_STB[0];
   assign rx_pop     = rd & (sel == 3'd0) & ~rx_empty;
   assign tx_pop     = (tx_st == IDLE) & ~tx_empty;
   assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
   assign rx_ovr_set = rx_push & rx_full & ~rx_pop;
   assign tx_idle    = tx_empty & (tx_st == IDLE);
   assign err        = rx_ovr | frm_err | tx_ovf;
   assign half       = ({1'b0, rx_div} + 17'd1) >> 1;

   assign unused = ^{WBs_ADR[ADDRWIDTH-1:5], WBs_ADR[1:0],
                     WBs_BYTE_STB[3:2], WBs_WR_DAT[31:16], half[16]};

   wb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(WB_CLK), .rst(WB_RST), .push(tx_push), .din(WBs_WR_DAT[7:0]),
      .pop(tx_pop), .dout(tx_head), .count(tx_count),
      .full(tx_full), .empty(tx_empty)
   );

   wb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(WB_CLK), .rst(WB_RST), .push(rx_push), .din(rx_sh),
      .pop(rx_pop), .dout(rx_head), .count(rx_count),
      .full(rx_full), .empty(rx_empty)
   );

   assign status = {8'd0, 8'(tx_count), 8'(rx_count), 2'd0,
                    tx_ovf, frm_err, rx_ovr, tx_idle, tx_full, ~rx_empty};

   always_comb begin
      rdat = '0;
      if (WBs_ACK) begin
         case (sel)
            3'd0:    rdat = rx_empty ? 32'd0 : {24'd0, rx_head};
            3'd1:    rdat = status;
            3'd2:    rdat = {16'd0, div};
            3'd3:    rdat = {29'd0, ie};
            default: rdat = DEFAULT_READ_VALUE;
         endcase
      end
   end
   assign WBs_RD_DAT = rdat;

   always_comb begin
      div_new[15:8] = WBs_BYTE_STB[1] ? WBs_WR_DAT[15:8] : div[15:8];
      div_new[7:0]  = WBs_BYTE_STB[0] ? WBs_WR_DAT[7:0]  : div[7:0];
   end

   always_ff @(posedge WB_CLK or posedge WB_RST) begin
      if (WB_RST) begin
         WBs_ACK     <= 1'b0;
         div         <= DEFAULT_DIV;
         ie          <= 3'd0;
         rx_ovr      <= 1'b0;
         frm_err     <= 1'b0;
         tx_ovf      <= 1'b0;
         UART_Intr_o <= 1'b0;
      end else begin
         WBs_ACK <= WBs_CYC & WBs_STB & ~WBs_ACK;
         if (wr & (sel == 3'd2))
            div <= (div_new < 16'd3) ? 16'd3 : div_new;
         if (wr & (sel == 3'd3) & WBs_BYTE_STB[0])
            ie <= WBs_WR_DAT[2:0];
         // a set event in the same cycle outranks the clear
         rx_ovr  <= rx_ovr_set | (rx_ovr  & ~(w1c & WBs_WR_DAT[3]));
         frm_err <= frm_set    | (frm_err & ~(w1c & WBs_WR_DAT[4]));
         tx_ovf  <= tx_ovf_set | (tx_ovf  & ~(w1c & WBs_WR_DAT[5]));
         UART_Intr_o <= |(ie & {err, tx_idle, ~rx_empty});
      end
   end

   always_ff @(posedge WB_CLK or posedge WB_RST) begin
      if (WB_RST) begin
         tx_st       <= IDLE;
         UART_SOUT_o <= 1'b1;
         tx_cnt      <= '0;
         tx_div      <= DEFAULT_DIV;
         tx_sh       <= '0;
         tx_bit      <= '0;
      end else begin
         case (tx_st)
            IDLE: if (!tx_empty) begin
               tx_sh       <= tx_head;
               tx_div      <= div;
               tx_cnt      <= '0;
               UART_SOUT_o <= 1'b0;
               tx_st       <= START;
            end
            START: if (tx_cnt == tx_div) begin
               tx_cnt      <= '0;
               tx_bit      <= '0;
               UART_SOUT_o <= tx_sh[0];
               tx_st       <= DATA;
            end else tx_cnt <= tx_cnt + 1'b1;
            DATA: if (tx_cnt == tx_div) begin
               tx_cnt <= '0;
               if (tx_bit == 3'd7) begin
                  UART_SOUT_o <= 1'b1;
                  tx_st       <= STOP;
               end else begin
                  tx_sh       <= tx_sh >> 1;
                  UART_SOUT_o <= tx_sh[1];
                  tx_bit      <= tx_bit + 1'b1;
               end
            end else tx_cnt <= tx_cnt + 1'b1;
            STOP: if (tx_cnt == tx_div) tx_st <= IDLE;
                  else tx_cnt <= tx_cnt + 1'b1;
            default: tx_st <= IDLE;
         endcase
      end
   end

   always_ff @(posedge WB_CLK or posedge WB_RST) begin
      if (WB_RST) begin
         {s1, s2, s3} <= 3'b111;
         rx_st   <= IDLE;
         rx_cnt  <= '0;
         rx_div  <= DEFAULT_DIV;
         rx_sh   <= '0;
         rx_bit  <= '0;
         rx_push <= 1'b0;
         frm_set <= 1'b0;
      end else begin
         {s1, s2, s3} <= {UART_SIN_i, s1, s2};
         rx_push <= 1'b0;
         frm_set <= 1'b0;
         case (rx_st)
            // the detect cycle counts toward the half-bit wait
            IDLE: if (s3 & ~s2) begin
               rx_st  <= START;
               rx_cnt <= 16'd1;
               rx_div <= div;
            end
            START: if (rx_cnt == half[15:0]) begin
               rx_cnt <= '0;
               rx_bit <= '0;
               rx_st  <= s2 ? IDLE : DATA;
            end else rx_cnt <= rx_cnt + 1'b1;
            DATA: if (rx_cnt == rx_div) begin
               rx_cnt <= '0;
               rx_sh  <= {s2, rx_sh[7:1]};
               rx_bit <= rx_bit + 1'b1;
               if (rx_bit == 3'd7) rx_st <= STOP;
            end else rx_cnt <= rx_cnt + 1'b1;
            STOP: if (rx_cnt == rx_div) begin
               rx_st   <= IDLE;
               rx_push <= s2;
               frm_set <= ~s2;
            end else rx_cnt <= rx_cnt + 1'b1;
            default: rx_st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_uart_fifo.sv
// Directed bench for wb_uart_fifo: bus map, TX waveform, loopback,
// overflow/framing flags, interrupt and async reset.
module tb_wb_uart_fifo;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  adr = '0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  bstb = '0;
   logic [31:0] wdat = '0;
   logic [31:0] rdat;
   logic        ack, sout, intr;
   logic        loop = 1'b0, sin_drv = 1'b1;
   logic        sin;

   int tests = 0;
   int fails = 0;

   assign sin = loop ? sout : sin_drv;

   always #5 clk = ~clk;

   wb_uart_fifo dut (
      .WB_CLK(clk), .WB_RST(rst), .WBs_ADR(adr), .WBs_CYC(cyc),
      .WBs_STB(stb), .WBs_WE(we), .WBs_BYTE_STB(bstb),
      .WBs_WR_DAT(wdat), .WBs_RD_DAT(rdat), .WBs_ACK(ack),
      .UART_SIN_i(sin), .UART_SOUT_o(sout), .UART_Intr_o(intr)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus(input logic w, input logic [9:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      output logic [31:0] r);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; bstb = be;
      @(negedge clk);
      check("ack", ack, 1);
      r = rdat;
      @(posedge clk);
      #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; bstb = '0;
   endtask

   task automatic wr32(input logic [9:0] a, input logic [31:0] d);
      logic [31:0] r;
      bus(1'b1, a, d, 4'hF, r);
   endtask

   task automatic rd32(input logic [9:0] a, output logic [31:0] r);
      bus(1'b0, a, 32'd0, 4'h0, r);
   endtask

   // one frame at 4 clocks per bit, then a short idle
   task automatic send(input logic [7:0] b, input logic sb);
      logic [9:0] f;
      f = {sb, b, 1'b0};
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         sin_drv = f[i];
         repeat (4) @(negedge clk);
      end
      sin_drv = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   function automatic logic [7:0] dval(input int i);
      return 8'(i * 37 + 5);
   endfunction

   initial begin
      logic [31:0] r;
      logic [39:0] obs, expw;
      logic [9:0]  frame;
      int          found;

      repeat (3) @(negedge clk);
      check("rst_sout", sout, 1);
      check("rst_intr", intr, 0);
      check("rst_ack", ack, 0);
      check("rst_rdat", rdat, 0);
      rst = 1'b0;
      rd32(10'h04, r); check("status_rst", r, 32'h4);
      rd32(10'h08, r); check("div_rst", r, 32'd103);
      rd32(10'h1C, r); check("unmapped", r, 32'hBADFABAC);
      wr32(10'h08, 32'd1);
      rd32(10'h08, r); check("div_clamp", r, 32'd3);
      bus(1'b1, 10'h08, 32'h0000_0100, 4'b0010, r);
      rd32(10'h08, r); check("div_bytestb", r, 32'h103);
      wr32(10'h08, 32'd3);

      wr32(10'h00, 32'h55);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         @(negedge clk);
         if (sout == 1'b0) found = 1;
      end
      check("tx_start_seen", found, 1);
      frame = {1'b1, 8'h55, 1'b0};
      for (int k = 0; k < 40; k++) begin
         obs[k]  = sout;
         expw[k] = frame[k / 4];
         @(negedge clk);
      end
      check("tx_wave", obs, expw);
      repeat (10) @(negedge clk);
      rd32(10'h04, r); check("tx_idle", r, 32'h4);

      loop = 1'b1;
      wr32(10'h00, 32'hA5);
      wr32(10'h00, 32'h3C);
      repeat (150) @(negedge clk);
      rd32(10'h04, r); check("rx_two_status", r, 32'h205);
      rd32(10'h00, r); check("rx_a5", r, 32'hA5);
      rd32(10'h00, r); check("rx_3c", r, 32'h3C);
      rd32(10'h00, r); check("rx_empty_read", r, 32'h0);
      rd32(10'h04, r); check("rx_cnt0", r, 32'h4);
      loop = 1'b0;

      wr32(10'h08, 32'd200);
      wr32(10'h00, 32'h00);
      for (int i = 0; i < 17; i++) wr32(10'h00, 32'(i));
      rd32(10'h04, r); check("tx_ovf_status", r, 32'h0010_0022);
      wr32(10'h04, 32'h20);
      rd32(10'h04, r); check("tx_ovf_clr", r, 32'h0010_0002);
      check("sout_mid_start", sout, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check("sout_async_rst", sout, 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rd32(10'h04, r); check("status_after_rst", r, 32'h4);

      wr32(10'h08, 32'd3);
      send(8'h5A, 1'b0);
      repeat (10) @(negedge clk);
      rd32(10'h04, r); check("frm_err_status", r, 32'h14);
      check("intr_masked", intr, 0);
      wr32(10'h0C, 32'd4);
      check("intr_lag", intr, 0);
      @(posedge clk); #1 check("intr_set", intr, 1);
      wr32(10'h04, 32'h10);
      @(posedge clk); #1 check("intr_clr", intr, 0);
      rd32(10'h04, r); check("frm_cleared", r, 32'h4);

      for (int i = 0; i < 17; i++) send(dval(i), 1'b1);
      repeat (10) @(negedge clk);
      rd32(10'h04, r); check("rx_ovr_status", r, 32'h0000_100D);
      check("intr_ovr", intr, 1);
      for (int i = 0; i < 16; i++) begin
         rd32(10'h00, r);
         check($sformatf("rx_byte%0d", i), r, {24'd0, dval(i)});
      end
      rd32(10'h04, r); check("rx_drained", r, 32'hC);
      wr32(10'h04, 32'h08);
      rd32(10'h04, r); check("rx_ovr_clr", r, 32'h4);
      @(posedge clk); #1 check("intr_final", intr, 0);
      rd32(10'h0C, r); check("ie_read", r, 32'h4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
